// File: rtl/dbg_seq_pkg.sv
// Shared types and constants for the debug RAM load/dump sequencer.
// Macro DBG_SEQ_CHECKSUM_EN (see debug_ram_sequencer) does not affect this package.
package dbg_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        DUMP_RD   = 3'd2,
        DUMP_WAIT = 3'd3,
        DUMP_OUT  = 3'd4,
        FIN       = 3'd5
    } seq_state_t;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_DUMP = 1'b1;

    localparam logic SEL_DATA = 1'b0;
    localparam logic SEL_INST = 1'b1;

    localparam int DEFAULT_BRAMWORDS = 4096;

    // Word index -> byte address on a 32-bit bus, low two bits always zero.
    function automatic logic [31:0] word_to_byte(input logic [29:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/debug_ram_sequencer.sv
// Debug sequencer that loads a word stream into, or dumps a word stream out of,
// DataRAM/InstRAM through their second ports. Optional macro: DBG_SEQ_CHECKSUM_EN.
module debug_ram_sequencer
    import dbg_seq_pkg::*;
#(
    parameter int BRAMWORDS = DEFAULT_BRAMWORDS,
    parameter int CNT_W     = 13
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST_N,
    input  logic             start,
    input  logic             mode,
    input  logic             ram_sel,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_cnt,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [31:0]      out_addr,
    input  logic             out_ready,
    output logic [31:0]      DataRAM_A2,
    output logic [31:0]      DataRAM_WD2,
    output logic [3:0]       DataRAM_WE2,
    input  logic [31:0]      DataRAM_RD2,
    output logic [31:0]      InstRAM_A2,
    output logic [31:0]      InstRAM_WD2,
    output logic [3:0]       InstRAM_WE2,
    input  logic [31:0]      InstRAM_RD2,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             cpu_hold,
    output logic [31:0]      checksum
);

    localparam int AW = $clog2(BRAMWORDS);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic             r_sel;
    logic [AW-1:0]    r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_out_data;
    logic [31:0]      r_out_addr;
    logic             r_aborted;

    logic        w_busy;
    logic        w_abort;
    logic        w_start;
    logic        w_beat;
    logic        w_hs;
    logic        w_last;
    logic        w_drive;
    logic [31:0] w_addr;
    logic [31:0] w_rd;
    logic [3:0]  w_we;
    logic        w_unused_addr_bits;

    assign w_busy  = (r_state != IDLE);
    assign w_abort = abort && w_busy;
    assign w_start = (r_state == IDLE) && start;
    assign w_last  = (r_cnt == CNT_W'(1));

    // Abort and reset both veto a beat so nothing reaches the RAM in that cycle.
    assign w_beat  = (r_state == LOAD) && in_valid && !abort && CPU_RST_N;
    assign w_hs    = (r_state == DUMP_OUT) && out_ready && !abort;

    assign w_drive = (r_state == LOAD) || (r_state == DUMP_RD) ||
                     (r_state == DUMP_WAIT) || (r_state == DUMP_OUT);
    assign w_addr  = word_to_byte(30'(r_idx));
    assign w_rd    = (r_sel == SEL_INST) ? InstRAM_RD2 : DataRAM_RD2;
    assign w_we    = w_beat ? 4'b1111 : 4'b0000;

    // Byte-lane bits and bits above the RAM size never affect addressing.
    assign w_unused_addr_bits = &{1'b0, base_addr[1:0], base_addr[31:AW+2]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (word_cnt == '0)
                        w_state_next = FIN;
                    else if (mode == MODE_DUMP)
                        w_state_next = DUMP_RD;
                    else
                        w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (w_beat && w_last)
                    w_state_next = FIN;
            end
            DUMP_RD:   w_state_next = DUMP_WAIT;
            DUMP_WAIT: w_state_next = DUMP_OUT;
            DUMP_OUT: begin
                if (w_hs)
                    w_state_next = w_last ? FIN : DUMP_RD;
            end
            FIN:       w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
        if (w_abort)
            w_state_next = IDLE;
    end

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            r_sel      <= SEL_DATA;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
            r_out_addr <= '0;
            r_aborted  <= 1'b0;
        end else begin
            r_aborted <= w_abort;
            if (w_start) begin
                r_sel <= ram_sel;
                r_idx <= base_addr[AW+1:2];
                r_cnt <= word_cnt;
            end else if (w_beat || w_hs) begin
                r_idx <= r_idx + AW'(1);
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // RAM data for the address driven in DUMP_RD is valid during DUMP_WAIT.
            if ((r_state == DUMP_WAIT) && !abort) begin
                r_out_data <= w_rd;
                r_out_addr <= w_addr;
            end
        end
    end

`ifdef DBG_SEQ_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N)
            r_checksum <= '0;
        else if (w_start)
            r_checksum <= '0;
        else if (w_beat)
            r_checksum <= r_checksum + in_data;
        else if (w_hs)
            r_checksum <= r_checksum + r_out_data;
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign in_ready  = (r_state == LOAD) && CPU_RST_N;
    assign out_valid = (r_state == DUMP_OUT);
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;

    assign DataRAM_A2  = (w_drive && r_sel == SEL_DATA) ? w_addr : '0;
    assign DataRAM_WD2 = (w_beat && r_sel == SEL_DATA) ? in_data : '0;
    assign DataRAM_WE2 = (r_sel == SEL_DATA) ? w_we : 4'b0000;
    assign InstRAM_A2  = (w_drive && r_sel == SEL_INST) ? w_addr : '0;
    assign InstRAM_WD2 = (w_beat && r_sel == SEL_INST) ? in_data : '0;
    assign InstRAM_WE2 = (r_sel == SEL_INST) ? w_we : 4'b0000;

    assign busy     = w_busy;
    assign done     = (r_state == FIN) && !abort;
    assign aborted  = r_aborted;
    // The CPU stays held while the sequencer itself is held in reset.
    assign cpu_hold = w_busy || !CPU_RST_N;

endmodule
